// File: rtl/alu_pipe_hs.sv
// ---------------------------------------------------------------------------
// alu_pipe_hs
//   Handshaked, parametrised ALU. It accepts one operand beat at a time on a
//   valid/ready input channel and presents a registered result with
//   carry/zero/overflow flags on a valid/ready output channel.
//
//   Operation groups (select_i):
//     000 arithmetic (select_calculation_i: add, sub, inc, dec)
//     001 logic      (select_logic_i: and, or, xor, not-a)
//     010 shl, 011 shr (logical), 100 rol, 101 ror   amount = b_i[SHW-1:0]
//     110 mul        iterative shift-add, WIDTH cycles
//     111 pass       result = b_i
//
// Ports
//   clk_i                 clock, rising edge
//   rst_i                 synchronous reset, active-high
//   in_valid_i/in_ready_o operand channel handshake
//   a_i, b_i              operands (b_i also carries the shift amount)
//   cin_i                 carry/borrow in, arithmetic group only
//   select_i              operation group
//   select_calculation_i  arithmetic sub-op
//   select_logic_i        logic sub-op
//   out_valid_o/out_ready_i result channel handshake
//   final_o               result
//   carry_o, zero_o, overflow_o  flags, valid together with out_valid_o
//   busy_o                multiply in progress
// ---------------------------------------------------------------------------
module alu_pipe_hs #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    input  logic [2:0]       select_i,
    input  logic [1:0]       select_calculation_i,
    input  logic [1:0]       select_logic_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] final_o,
    output logic             carry_o,
    output logic             zero_o,
    output logic             overflow_o,
    output logic             busy_o
);

    localparam int SHW = $clog2(WIDTH);

    localparam logic [2:0] SEL_ARITH = 3'b000;
    localparam logic [2:0] SEL_LOGIC = 3'b001;
    localparam logic [2:0] SEL_SHL   = 3'b010;
    localparam logic [2:0] SEL_SHR   = 3'b011;
    localparam logic [2:0] SEL_ROL   = 3'b100;
    localparam logic [2:0] SEL_ROR   = 3'b101;
    localparam logic [2:0] SEL_MUL   = 3'b110;
    localparam logic [2:0] SEL_PASS  = 3'b111;

    localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);
    localparam logic [SHW-1:0] CNT_ONE  = SHW'(1);
    localparam logic [WIDTH:0] ONE_EXT  = {{WIDTH{1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

    typedef struct packed {
        logic [WIDTH-1:0] res;
        logic             carry;
        logic             ovf;
    } alu_res_t;

    // Arithmetic group. Sums are formed one bit wider so the top bit is the
    // carry-out for add/inc and the borrow (negative true result) for sub/dec.
    function automatic alu_res_t arith_op(
        input logic [1:0]       sub_op,
        input logic [WIDTH-1:0] op_a,
        input logic [WIDTH-1:0] op_b,
        input logic             cin
    );
        logic [WIDTH:0] wide;
        logic [WIDTH:0] cin_ext;
        alu_res_t       r;
        cin_ext = {{WIDTH{1'b0}}, cin};
        wide    = '0;
        r       = '0;
        case (sub_op)
            2'b00: begin
                wide  = {1'b0, op_a} + {1'b0, op_b} + cin_ext;
                // Same-sign operands producing a different-sign result.
                r.ovf = (op_a[WIDTH-1] == op_b[WIDTH-1]) &&
                        (wide[WIDTH-1] != op_a[WIDTH-1]);
            end
            2'b01: begin
                wide  = {1'b0, op_a} - {1'b0, op_b} - cin_ext;
                // Opposite-sign operands where the result leaves a's sign.
                r.ovf = (op_a[WIDTH-1] != op_b[WIDTH-1]) &&
                        (wide[WIDTH-1] != op_a[WIDTH-1]);
            end
            2'b10: begin
                wide  = {1'b0, op_a} + ONE_EXT;
                r.ovf = !op_a[WIDTH-1] && wide[WIDTH-1];
            end
            2'b11: begin
                wide  = {1'b0, op_a} - ONE_EXT;
                r.ovf = op_a[WIDTH-1] && !wide[WIDTH-1];
            end
            default: begin
                wide  = '0;
                r.ovf = 1'b0;
            end
        endcase
        r.res   = wide[WIDTH-1:0];
        r.carry = wide[WIDTH];
        return r;
    endfunction

    // Logic group; carry and overflow are always clear.
    function automatic alu_res_t logic_op(
        input logic [1:0]       sub_op,
        input logic [WIDTH-1:0] op_a,
        input logic [WIDTH-1:0] op_b
    );
        alu_res_t r;
        r = '0;
        case (sub_op)
            2'b00:   r.res = op_a & op_b;
            2'b01:   r.res = op_a | op_b;
            2'b10:   r.res = op_a ^ op_b;
            2'b11:   r.res = ~op_a;
            default: r.res = '0;
        endcase
        return r;
    endfunction

    // Shift/rotate group. The extra bit next to the operand catches the last
    // bit shifted out, and is naturally 0 for a zero amount. Rotates use a
    // doubled operand so the amount is implicitly taken modulo WIDTH.
    function automatic alu_res_t shift_op(
        input logic [2:0]       sel,
        input logic [WIDTH-1:0] op_a,
        input logic [SHW-1:0]   amt
    );
        logic [WIDTH:0]     wide;
        logic [2*WIDTH-1:0] dbl;
        alu_res_t           r;
        r    = '0;
        wide = '0;
        dbl  = '0;
        case (sel)
            SEL_SHL: begin
                wide    = {1'b0, op_a} << amt;
                r.res   = wide[WIDTH-1:0];
                r.carry = wide[WIDTH];
            end
            SEL_SHR: begin
                wide    = {op_a, 1'b0} >> amt;
                r.res   = wide[WIDTH:1];
                r.carry = wide[0];
            end
            SEL_ROL: begin
                dbl   = {op_a, op_a} << amt;
                r.res = dbl[2*WIDTH-1:WIDTH];
            end
            SEL_ROR: begin
                dbl   = {op_a, op_a} >> amt;
                r.res = dbl[WIDTH-1:0];
            end
            default: r.res = '0;
        endcase
        return r;
    endfunction

    // Registers
    state_t               state_q, state_d;
    logic [SHW-1:0]       count_q, count_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [2*WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic                 out_valid_q, out_valid_d;
    logic [WIDTH-1:0]     final_q, final_d;
    logic                 carry_q, carry_d;
    logic                 zero_q, zero_d;
    logic                 overflow_q, overflow_d;

    // Combinational helpers
    logic                 in_ready_s;
    logic                 accept_s;
    alu_res_t             alu_s;
    logic [2*WIDTH-1:0]   mul_sum_s;

    // A new beat may enter only when idle and the result slot is free or
    // being emptied in this same cycle.
    assign in_ready_s = (state_q == ST_IDLE) && (!out_valid_q || out_ready_i);
    assign accept_s   = in_valid_i && in_ready_s;

    // One shift-add step: add the shifted multiplicand when the current
    // multiplier LSB is set.
    assign mul_sum_s = acc_q + (mplier_q[0] ? mcand_q : {(2*WIDTH){1'b0}});

    // Single-cycle result selection from the live operands at accept.
    always_comb begin
        alu_s = '0;
        case (select_i)
            SEL_ARITH: alu_s = arith_op(select_calculation_i, a_i, b_i, cin_i);
            SEL_LOGIC: alu_s = logic_op(select_logic_i, a_i, b_i);
            SEL_SHL,
            SEL_SHR,
            SEL_ROL,
            SEL_ROR:   alu_s = shift_op(select_i, a_i, b_i[SHW-1:0]);
            SEL_PASS:  alu_s.res = b_i;
            SEL_MUL:   alu_s = '0;
            default:   alu_s = '0;
        endcase
    end

    // Next-state logic for the FSM, multiplier datapath and result register.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        acc_d       = acc_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        final_d     = final_q;
        carry_d     = carry_q;
        zero_d      = zero_q;
        overflow_d  = overflow_q;

        // A transfer empties the slot; a load below overrides this.
        if (out_valid_q && out_ready_i) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    if (select_i == SEL_MUL) begin
                        state_d  = ST_MUL;
                        count_d  = '0;
                        acc_d    = '0;
                        mcand_d  = {{WIDTH{1'b0}}, a_i};
                        mplier_d = b_i;
                    end else begin
                        final_d     = alu_s.res;
                        carry_d     = alu_s.carry;
                        overflow_d  = (select_i == SEL_ARITH) ? alu_s.ovf : 1'b0;
                        zero_d      = (alu_s.res == '0);
                        out_valid_d = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_MUL: begin
                acc_d    = mul_sum_s;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                if (count_q == CNT_LAST) begin
                    // Slot is guaranteed empty here: accept required it to
                    // be free or draining, and nothing loads during MUL.
                    final_d     = mul_sum_s[WIDTH-1:0];
                    carry_d     = |mul_sum_s[2*WIDTH-1:WIDTH];
                    overflow_d  = 1'b0;
                    zero_d      = (mul_sum_s[WIDTH-1:0] == '0);
                    out_valid_d = 1'b1;
                    state_d     = ST_IDLE;
                    count_d     = '0;
                end else begin
                    count_d = count_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                count_d = '0;
            end
        endcase
    end

    // State and result registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            count_q     <= '0;
            acc_q       <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            out_valid_q <= 1'b0;
            final_q     <= '0;
            carry_q     <= 1'b0;
            zero_q      <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            acc_q       <= acc_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            out_valid_q <= out_valid_d;
            final_q     <= final_d;
            carry_q     <= carry_d;
            zero_q      <= zero_d;
            overflow_q  <= overflow_d;
        end
    end

    assign in_ready_o  = in_ready_s;
    assign out_valid_o = out_valid_q;
    assign final_o     = final_q;
    assign carry_o     = carry_q;
    assign zero_o      = zero_q;
    assign overflow_o  = overflow_q;
    assign busy_o      = (state_q != ST_IDLE);

endmodule
